// File: rtl/stop_watch_pkg.sv
// Shared constants and helpers for the BCD stopwatch with lap hold.
package stop_watch_pkg;

  localparam int              BCD_W        = 4;
  localparam logic [BCD_W-1:0] BCD_MAX     = 4'd9;
  localparam int              DVSR_DEFAULT = 5000000;

  // Any nibble above 9 is not a legal BCD digit and saturates to 9.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD up/down digit with clear/load priority and a terminal flag
// (9 when counting up, 0 when counting down) for carry/borrow chaining.
module bcd_digit
  import stop_watch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             en,
  input  logic             down,
  output logic [BCD_W-1:0] digit,
  output logic             term
);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    // NOTE: default assignment first so every path drives digit_d; no latch.
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = bcd_sat(load_val);
    end else if (en) begin
      if (down) digit_d = (digit_q == '0)      ? BCD_MAX : digit_q - BCD_W'(1);
      else      digit_d = (digit_q == BCD_MAX) ? '0      : digit_q + BCD_W'(1);
    end
  end

  // NOTE: non-blocking assignment for state so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign term  = down ? (digit_q == '0) : (digit_q == BCD_MAX);

endmodule

// File: rtl/stop_watch_lap.sv
// Multi-digit BCD stopwatch: prescaler, up/down ripple of bcd_digit
// instances, overflow/underflow flags, and a lap register that freezes the display.
module stop_watch_lap
  import stop_watch_pkg::*;
#(
  parameter int DVSR = DVSR_DEFAULT,
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BCD_W*NDIG-1:0] load_val,
  input  logic                  down,
  input  logic                  lap,
  output logic [BCD_W*NDIG-1:0] digits,
  output logic                  tick,
  output logic                  wrap,
  output logic                  done,
  output logic                  held
);

  localparam int             PW         = $clog2(DVSR);
  localparam int             CW         = BCD_W * NDIG;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DVSR - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            held_q, held_d;
  logic [CW-1:0]   lap_q, lap_d;
  logic [CW-1:0]   count;
  logic [NDIG-1:0] term;
  logic [NDIG-1:0] dig_en;
  logic            adv, tick_int, all_term, one_left, step;

  always_comb begin
    adv      = go && !done_q && !clr && !load;
    tick_int = adv && (presc_q == PRESC_LAST);
    all_term = &term;
    // In down mode all-terminal means the count is zero; never roll to all-9s.
    step     = tick_int && !(down && all_term);
    one_left = (count == CW'(1));

    presc_d = presc_q;
    done_d  = done_q;
    held_d  = held_q;
    lap_d   = lap_q;
    if (clr) begin
      presc_d = '0;
      done_d  = 1'b0;
      held_d  = 1'b0;
    end else begin
      if (lap) begin
        if (!held_q) begin
          lap_d  = count;
          held_d = 1'b1;
        end else begin
          held_d = 1'b0;
        end
      end
      if (load) begin
        presc_d = '0;
        done_d  = 1'b0;
      end else begin
        if (adv) presc_d = tick_int ? '0 : presc_q + PW'(1);
        if (go && down && all_term)    done_d = 1'b1;
        if (tick_int && down && one_left) done_d = 1'b1;
      end
    end
  end

  always_comb begin
    logic carry;
    carry = step;
    for (int k = 0; k < NDIG; k++) begin
      dig_en[k] = carry;
      carry     = carry & term[k];
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[BCD_W*k +: BCD_W]),
      .en       (dig_en[k]),
      .down     (down),
      .digit    (count[BCD_W*k +: BCD_W]),
      .term     (term[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      done_q  <= 1'b0;
      held_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      presc_q <= presc_d;
      done_q  <= done_d;
      held_q  <= held_d;
      lap_q   <= lap_d;
    end
  end

  assign tick   = tick_int;
  assign wrap   = tick_int && !down && all_term;
  assign digits = held_q ? lap_q : count;
  assign done   = done_q;
  assign held   = held_q;

endmodule
